// File: rtl/if_id_hazard_ctrl_pkg.sv
// Shared constants for the IF/ID sequencing controller: datapath word size,
// default register-specifier width and the controller state encodings.
package if_id_hazard_ctrl_pkg;

    localparam int WORD_SIZE      = 16;
    localparam int REG_ADDR_W_DEF = 2;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        FETCH_WAIT = 2'd1,
        HALTED     = 2'd2
    } ctrlState_t;

endpackage

// File: rtl/if_id_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
// Holds at all-ones instead of wrapping; i_clear has priority over i_inc.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    // Count up on each increment request, sticking at the maximum value
    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/if_id_hazard_ctrl.sv
// IF/ID pipeline sequencing controller. Decides every cycle, with zero
// latency, whether fetch advances, stalls, flushes or bubbles ID->EX based on
// load-use hazards, taken branches/jumps and the instruction-memory handshake.
module if_id_hazard_ctrl
    import if_id_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W    = REG_ADDR_W_DEF,
    parameter int CNT_W         = 16,
    parameter int FETCH_TIMEOUT = 64
) (
    input  logic                  i_Clk,
    input  logic                  i_Reset,
    input  logic [REG_ADDR_W-1:0] i_ID_rs,
    input  logic [REG_ADDR_W-1:0] i_ID_rt,
    input  logic                  i_ID_use_rs,
    input  logic                  i_ID_use_rt,
    input  logic                  i_ID_Jump,
    input  logic                  i_ID_Halt,
    input  logic                  i_EX_MemRead,
    input  logic [REG_ADDR_W-1:0] i_EX_rd,
    input  logic                  i_EX_BranchTaken,
    input  logic                  i_IMem_ready,
    input  logic                  i_DMem_busy,
    output logic                  o_IMem_req,
    output logic                  o_PC_Write,
    output logic                  o_IF_ID_Write,
    output logic                  o_IF_ID_Flush,
    output logic                  o_ID_EX_Bubble,
    output logic                  o_Halted,
    output logic                  o_Fetch_Timeout,
    output logic [CNT_W-1:0]      o_Stall_Cnt,
    output logic [CNT_W-1:0]      o_Flush_Cnt
);

    localparam int                WAIT_W     = $clog2(FETCH_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(FETCH_TIMEOUT);

    ctrlState_t        r_state;
    ctrlState_t        w_nextState;
    logic              r_idValid;
    logic              w_idValidNext;
    logic [WAIT_W-1:0] r_wait;
    logic [WAIT_W-1:0] w_waitNext;
    logic              w_waitCount;
    logic              w_setTimeout;
    logic              r_timeout;
    logic              w_loadUse;
    logic              w_stallInc;
    logic              w_flushInc;

    // A load in EX whose destination feeds a live source of the valid ID instruction
    assign w_loadUse = r_idValid & i_EX_MemRead &
                       ((i_ID_use_rs & (i_ID_rs == i_EX_rd)) |
                        (i_ID_use_rt & (i_ID_rt == i_EX_rd)));

    // Same-cycle decision: control outputs, next state and counter increments
    always_comb begin
        w_nextState     = r_state;
        w_idValidNext   = r_idValid;
        w_waitNext      = r_wait;
        w_waitCount     = 1'b0;
        w_stallInc      = 1'b0;
        w_flushInc      = 1'b0;
        o_IMem_req      = 1'b0;
        o_PC_Write      = 1'b0;
        o_IF_ID_Write   = 1'b0;
        o_IF_ID_Flush   = 1'b0;
        o_ID_EX_Bubble  = 1'b0;
        o_Halted        = 1'b0;

        if (i_Reset) begin
            o_IF_ID_Flush  = 1'b1;
            o_ID_EX_Bubble = 1'b1;
        end else begin
            case (r_state)
                RUN: begin
                    o_IMem_req = 1'b1;
                    if (i_DMem_busy) begin
                        w_stallInc = 1'b1;
                    end else if (i_EX_BranchTaken) begin
                        o_PC_Write     = 1'b1;
                        o_IF_ID_Flush  = 1'b1;
                        o_ID_EX_Bubble = 1'b1;
                        w_idValidNext  = 1'b0;
                        w_flushInc     = 1'b1;
                    end else if (i_ID_Halt && r_idValid) begin
                        w_nextState = HALTED;
                    end else if (i_ID_Jump && r_idValid) begin
                        o_PC_Write    = 1'b1;
                        o_IF_ID_Flush = 1'b1;
                        w_idValidNext = 1'b0;
                        w_flushInc    = 1'b1;
                    end else if (w_loadUse) begin
                        o_ID_EX_Bubble = 1'b1;
                        w_stallInc     = 1'b1;
                    end else if (!i_IMem_ready) begin
                        o_ID_EX_Bubble = !r_idValid;
                        w_idValidNext  = 1'b0;
                        w_nextState    = FETCH_WAIT;
                        w_waitNext     = WAIT_W'(1);
                        w_waitCount    = 1'b1;
                        w_stallInc     = 1'b1;
                    end else begin
                        o_PC_Write     = 1'b1;
                        o_IF_ID_Write  = 1'b1;
                        o_ID_EX_Bubble = !r_idValid;
                        w_idValidNext  = 1'b1;
                    end
                end
                FETCH_WAIT: begin
                    o_IMem_req     = 1'b1;
                    o_ID_EX_Bubble = 1'b1;
                    if (i_DMem_busy) begin
                        o_ID_EX_Bubble = 1'b0;
                        w_stallInc     = 1'b1;
                    end else if (i_EX_BranchTaken || (i_ID_Jump && r_idValid)) begin
                        o_PC_Write    = 1'b1;
                        o_IF_ID_Flush = 1'b1;
                        w_idValidNext = 1'b0;
                        w_waitNext    = '0;
                        w_flushInc    = 1'b1;
                    end else if (i_IMem_ready) begin
                        o_PC_Write    = 1'b1;
                        o_IF_ID_Write = 1'b1;
                        w_idValidNext = 1'b1;
                        w_nextState   = RUN;
                    end else begin
                        if (r_wait != WAIT_LIMIT) begin
                            w_waitNext = r_wait + 1'b1;
                        end
                        w_waitCount = 1'b1;
                        w_stallInc  = 1'b1;
                    end
                end
                HALTED: begin
                    o_ID_EX_Bubble = 1'b1;
                    o_Halted       = 1'b1;
                end
                default: begin
                    w_nextState = RUN;
                end
            endcase
        end

        w_setTimeout = w_waitCount && (w_waitNext == WAIT_LIMIT);
    end

    // State, ID-valid flag, wait counter and sticky timeout registers
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_state   <= RUN;
            r_idValid <= 1'b0;
            r_wait    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_idValid <= w_idValidNext;
            r_wait    <= w_waitNext;
            if (w_setTimeout) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign o_Fetch_Timeout = r_timeout;

    sat_counter #(.CNT_W(CNT_W)) u_stallCnt (
        .i_clk   (i_Clk),
        .i_clear (i_Reset),
        .i_inc   (w_stallInc),
        .o_count (o_Stall_Cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flushCnt (
        .i_clk   (i_Clk),
        .i_clear (i_Reset),
        .i_inc   (w_flushInc),
        .o_count (o_Flush_Cnt)
    );

endmodule

// File: tb/tb_if_id_hazard_ctrl.sv
// Scoreboard testbench for if_id_hazard_ctrl with 4-bit counters so that
// saturation is reachable in a short run.
module tb_if_id_hazard_ctrl;

    localparam int RW = 2;
    localparam int CW = 4;
    localparam int TO = 64;

    typedef struct {
        logic          reset;
        logic          memRead;
        logic          branch;
        logic          jump;
        logic          halt;
        logic          useRs;
        logic          useRt;
        logic          imemReady;
        logic          dmemBusy;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic [RW-1:0] exRd;
    } stim_t;

    typedef struct {
        string         name;
        logic          pcw;
        logic          ifw;
        logic          flush;
        logic          bub;
        logic          req;
        logic          halted;
        logic          tmo;
        logic [CW-1:0] stall;
        logic [CW-1:0] flushCnt;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [RW-1:0] idRs, idRt, exRd;
    logic          useRs, useRt, jump, halt, memRead, branch, imemReady, dmemBusy;
    logic          imemReq, pcWrite, ifIdWrite, ifIdFlush, idExBubble, halted, fetchTimeout;
    logic [CW-1:0] stallCnt, flushCnt;

    exp_t  sb[$];
    exp_t  mon;
    stim_t s;
    int    checks   = 0;
    int    failures = 0;

    always #5 clk = ~clk;

    if_id_hazard_ctrl #(.REG_ADDR_W(RW), .CNT_W(CW), .FETCH_TIMEOUT(TO)) dut (
        .i_Clk            (clk),
        .i_Reset          (reset),
        .i_ID_rs          (idRs),
        .i_ID_rt          (idRt),
        .i_ID_use_rs      (useRs),
        .i_ID_use_rt      (useRt),
        .i_ID_Jump        (jump),
        .i_ID_Halt        (halt),
        .i_EX_MemRead     (memRead),
        .i_EX_rd          (exRd),
        .i_EX_BranchTaken (branch),
        .i_IMem_ready     (imemReady),
        .i_DMem_busy      (dmemBusy),
        .o_IMem_req       (imemReq),
        .o_PC_Write       (pcWrite),
        .o_IF_ID_Write    (ifIdWrite),
        .o_IF_ID_Flush    (ifIdFlush),
        .o_ID_EX_Bubble   (idExBubble),
        .o_Halted         (halted),
        .o_Fetch_Timeout  (fetchTimeout),
        .o_Stall_Cnt      (stallCnt),
        .o_Flush_Cnt      (flushCnt)
    );

    function automatic exp_t mkExp(input string name, input logic pcw, input logic ifw,
                                   input logic fl, input logic bub, input logic req,
                                   input logic hlt, input logic tmo,
                                   input int stall, input int flc);
        exp_t e;
        e.name     = name;
        e.pcw      = pcw;
        e.ifw      = ifw;
        e.flush    = fl;
        e.bub      = bub;
        e.req      = req;
        e.halted   = hlt;
        e.tmo      = tmo;
        e.stall    = CW'(stall);
        e.flushCnt = CW'(flc);
        return e;
    endfunction

    function automatic int sat15(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic drive(input stim_t v);
        reset     = v.reset;
        memRead   = v.memRead;
        branch    = v.branch;
        jump      = v.jump;
        halt      = v.halt;
        useRs     = v.useRs;
        useRt     = v.useRt;
        imemReady = v.imemReady;
        dmemBusy  = v.dmemBusy;
        idRs      = v.rs;
        idRt      = v.rt;
        exRd      = v.exRd;
    endtask

    task automatic applyStimulus(input stim_t v, input exp_t e);
        @(posedge clk);
        #1;
        drive(v);
        sb.push_back(e);
    endtask

    task automatic checkOutput(input string name, input string field,
                               input logic [CW-1:0] act, input logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s.%s: got %0h, expected %0h at %0t", name, field, act, exp, $time);
        end
    endtask

    // Monitor: outputs are presented every cycle, compared mid-cycle
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                mon = sb.pop_front();
                checkOutput(mon.name, "PC_Write",      CW'(pcWrite),      CW'(mon.pcw));
                checkOutput(mon.name, "IF_ID_Write",   CW'(ifIdWrite),    CW'(mon.ifw));
                checkOutput(mon.name, "IF_ID_Flush",   CW'(ifIdFlush),    CW'(mon.flush));
                checkOutput(mon.name, "ID_EX_Bubble",  CW'(idExBubble),   CW'(mon.bub));
                checkOutput(mon.name, "IMem_req",      CW'(imemReq),      CW'(mon.req));
                checkOutput(mon.name, "Halted",        CW'(halted),       CW'(mon.halted));
                checkOutput(mon.name, "Fetch_Timeout", CW'(fetchTimeout), CW'(mon.tmo));
                checkOutput(mon.name, "Stall_Cnt",     stallCnt,          mon.stall);
                checkOutput(mon.name, "Flush_Cnt",     flushCnt,          mon.flushCnt);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        s = '{reset: 1'b1, imemReady: 1'b1, default: '0};
        drive(s);

        // Reset held for three cycles
        for (int i = 0; i < 3; i++) applyStimulus(s, mkExp("reset", 0,0,1,1,0,0,0, 0,0));

        // Release: first fetch bubbles ID->EX, second does not
        s.reset = 1'b0;
        applyStimulus(s, mkExp("first",  1,1,0,1,1,0,0, 0,0));
        applyStimulus(s, mkExp("second", 1,1,0,0,1,0,0, 0,0));

        // Load-use through rs
        s.memRead = 1'b1; s.exRd = 2'd2; s.rs = 2'd2; s.useRs = 1'b1;
        applyStimulus(s, mkExp("loaduse_rs", 0,0,0,1,1,0,0, 0,0));
        s.memRead = 1'b0;
        applyStimulus(s, mkExp("after_lu", 1,1,0,0,1,0,0, 1,0));

        // Load to a register not read, then the same register read through rt
        s.memRead = 1'b1; s.exRd = 2'd3; s.rt = 2'd3; s.useRt = 1'b0;
        applyStimulus(s, mkExp("no_hazard", 1,1,0,0,1,0,0, 1,0));
        s.useRt = 1'b1;
        applyStimulus(s, mkExp("loaduse_rt", 0,0,0,1,1,0,0, 1,0));
        s.memRead = 1'b0; s.useRs = 1'b0; s.useRt = 1'b0;
        applyStimulus(s, mkExp("after_lu_rt", 1,1,0,0,1,0,0, 2,0));

        // Branch together with load-use: branch wins, no stall counted
        s.memRead = 1'b1; s.exRd = 2'd2; s.rs = 2'd2; s.useRs = 1'b1; s.branch = 1'b1;
        applyStimulus(s, mkExp("branch_lu", 1,0,1,1,1,0,0, 2,0));
        s.branch = 1'b0;
        applyStimulus(s, mkExp("lu_invalid_id", 1,1,0,1,1,0,0, 2,1));
        s.memRead = 1'b0; s.useRs = 1'b0;
        applyStimulus(s, mkExp("after_br", 1,1,0,0,1,0,0, 2,1));

        // Jump resolved in ID
        s.jump = 1'b1;
        applyStimulus(s, mkExp("jump", 1,0,1,0,1,0,0, 2,1));
        s.jump = 1'b0;
        applyStimulus(s, mkExp("after_jump", 1,1,0,1,1,0,0, 2,2));
        applyStimulus(s, mkExp("run1", 1,1,0,0,1,0,0, 2,2));

        // Halt squashed by a simultaneous branch
        s.halt = 1'b1; s.branch = 1'b1;
        applyStimulus(s, mkExp("halt_squash", 1,0,1,1,1,0,0, 2,2));
        s.halt = 1'b0; s.branch = 1'b0;
        applyStimulus(s, mkExp("after_squash", 1,1,0,1,1,0,0, 2,3));
        applyStimulus(s, mkExp("run2", 1,1,0,0,1,0,0, 2,3));

        // Reset clears the counters
        s.reset = 1'b1;
        applyStimulus(s, mkExp("rst_a", 0,0,1,1,0,0,0, 2,3));
        applyStimulus(s, mkExp("rst_b", 0,0,1,1,0,0,0, 0,0));
        s.reset = 1'b0;
        applyStimulus(s, mkExp("rel", 1,1,0,1,1,0,0, 0,0));
        applyStimulus(s, mkExp("run3", 1,1,0,0,1,0,0, 0,0));

        // Instruction memory not ready for 5 cycles
        s.imemReady = 1'b0;
        applyStimulus(s, mkExp("fw_enter", 0,0,0,0,1,0,0, 0,0));
        for (int k = 2; k <= 5; k++) applyStimulus(s, mkExp("fw_wait", 0,0,0,1,1,0,0, k-1,0));
        s.imemReady = 1'b1;
        applyStimulus(s, mkExp("fw_ready", 1,1,0,1,1,0,0, 5,0));
        applyStimulus(s, mkExp("fw_run",   1,1,0,0,1,0,0, 5,0));

        // Not ready for 64 cycles: timeout appears after the 64th, stall saturates
        s.imemReady = 1'b0;
        applyStimulus(s, mkExp("to_enter", 0,0,0,0,1,0,0, 5,0));
        for (int i = 2; i <= 64; i++) applyStimulus(s, mkExp("to_wait", 0,0,0,1,1,0,0, sat15(4+i),0));
        s.imemReady = 1'b1;
        applyStimulus(s, mkExp("to_ready",  1,1,0,1,1,0,1, 15,0));
        applyStimulus(s, mkExp("to_sticky", 1,1,0,0,1,0,1, 15,0));

        // Halt, stay halted for 10 cycles, leave only through reset
        s.halt = 1'b1;
        applyStimulus(s, mkExp("halt", 0,0,0,0,1,0,1, 15,0));
        s.halt = 1'b0;
        for (int i = 0; i < 10; i++) applyStimulus(s, mkExp("halted", 0,0,0,1,0,1,1, 15,0));
        s.reset = 1'b1;
        applyStimulus(s, mkExp("h_rst_a", 0,0,1,1,0,0,1, 15,0));
        applyStimulus(s, mkExp("h_rst_b", 0,0,1,1,0,0,0, 0,0));
        s.reset = 1'b0;
        applyStimulus(s, mkExp("h_rel", 1,1,0,1,1,0,0, 0,0));

        // DMem busy for 20 cycles (a branch in the first one is frozen out)
        s.dmemBusy = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            s.branch = (i == 1);
            applyStimulus(s, mkExp("busy", 0,0,0,0,1,0,0, sat15(i-1),0));
        end
        s.dmemBusy = 1'b0; s.branch = 1'b0;
        applyStimulus(s, mkExp("busy_done", 1,1,0,0,1,0,0, 15,0));

        // Reset during a fetch wait abandons it
        s.imemReady = 1'b0;
        applyStimulus(s, mkExp("mw_enter", 0,0,0,0,1,0,0, 15,0));
        applyStimulus(s, mkExp("mw_wait",  0,0,0,1,1,0,0, 15,0));
        s.reset = 1'b1;
        applyStimulus(s, mkExp("mw_rst", 0,0,1,1,0,0,0, 15,0));
        s.reset = 1'b0; s.imemReady = 1'b1;
        applyStimulus(s, mkExp("mw_rel", 1,1,0,1,1,0,0, 0,0));

        repeat (2) @(posedge clk);
        if (sb.size() > 0) begin
            failures++;
            $display("[TB] FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_id_hazard_ctrl.md
Name: if_id_hazard_ctrl

Overview:
- Pipeline sequencing controller for the IF/ID stage register and the PC.
- Each cycle it decides whether to advance fetch, stall it, flush it or bubble ID→EX, from three sources: load-use hazards, taken branches/jumps, and a multi-cycle instruction-memory handshake.
- Drives PC_Write, IF_ID_Write, IF_ID_Flush and ID_EX_Bubble.
- Keeps saturating stall/flush performance counters and a sticky fetch-timeout error.

Parameters:
- REG_ADDR_W, 2, register-specifier width.
- CNT_W, 16, width of the performance counters.
- FETCH_TIMEOUT, 64, fetch-wait cycles before Fetch_Timeout is set.

Ports:
- Clk  in  1  clock; one clock domain.
- Reset  in  1  reset is synchronous and active-high.
- ID_rs  in  REG_ADDR_W  source register 1 of the instruction in ID.
- ID_rt  in  REG_ADDR_W  source register 2 of the instruction in ID.
- ID_use_rs  in  1  ID instruction reads rs.
- ID_use_rt  in  1  ID instruction reads rt.
- ID_Jump  in  1  ID instruction is a jump (target resolved in ID).
- ID_Halt  in  1  ID instruction is HLT.
- EX_MemRead  in  1  EX instruction is a load.
- EX_rd  in  REG_ADDR_W  load destination register in EX.
- EX_BranchTaken  in  1  branch in EX resolved taken.
- IMem_ready  in  1  fetched instruction is valid this cycle.
- DMem_busy  in  1  data memory busy; freeze the whole front end.
- IMem_req  out  1  fetch request.
- PC_Write  out  1  PC update enable.
- IF_ID_Write  out  1  IF/ID capture enable.
- IF_ID_Flush  out  1  zero the IF/ID register.
- ID_EX_Bubble  out  1  insert a NOP into ID/EX.
- Halted  out  1  in HALTED state.
- Fetch_Timeout  out  1  sticky fetch-timeout error.
- Stall_Cnt  out  CNT_W  stall cycles, saturating.
- Flush_Cnt  out  CNT_W  flush events, saturating.

Behaviour:
- States: RUN, FETCH_WAIT, HALTED. Internal ID_Valid flag and a wait counter.
- Reset, checked at the posedge:
  - state←RUN, ID_Valid←0, counters←0, Fetch_Timeout←0.
  - While Reset=1, outputs are forced to: PC_Write=0, IF_ID_Write=0, IF_ID_Flush=1, ID_EX_Bubble=1, IMem_req=0, Halted=0.
  - A reset asserted mid-wait abandons the fetch immediately.
- Outputs are combinational from state and inputs; the decision is made in the same cycle (zero latency). IMem_req=1 in RUN and FETCH_WAIT.
- Hazard term: load_use = EX_MemRead & ((ID_use_rs & ID_rs==EX_rd) | (ID_use_rt & ID_rt==EX_rd)), qualified by ID_Valid.
- RUN priority, highest first:
  1. DMem_busy: PC_Write=0, IF_ID_Write=0, IF_ID_Flush=0, ID_EX_Bubble=0; no state or flag change; Stall_Cnt++.
  2. EX_BranchTaken: PC_Write=1, IF_ID_Flush=1, ID_EX_Bubble=1, ID_Valid←0; Flush_Cnt++.
  3. ID_Halt & ID_Valid: PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=0; →HALTED.
  4. ID_Jump & ID_Valid: PC_Write=1, IF_ID_Flush=1, ID_EX_Bubble=0, ID_Valid←0; Flush_Cnt++.
  5. load_use: PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1; Stall_Cnt++. The stall lasts exactly 1 cycle because the load leaves EX.
  6. !IMem_ready: PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=!ID_Valid, ID_Valid←0; →FETCH_WAIT, wait←1; Stall_Cnt++.
  7. Otherwise (advance): PC_Write=1, IF_ID_Write=1, ID_EX_Bubble=!ID_Valid, ID_Valid←1.
- FETCH_WAIT:
  - ID_EX_Bubble=1, IF_ID_Flush=0.
  - DMem_busy freezes as in RUN.
  - Branch/jump redirects are handled as in RUN: state stays FETCH_WAIT and the wait counter restarts at 0.
  - IMem_ready: PC_Write=1, IF_ID_Write=1, ID_Valid←1; →RUN.
  - Otherwise wait++ and Stall_Cnt++. When wait reaches FETCH_TIMEOUT, Fetch_Timeout←1 (sticky until Reset); waiting continues.
- HALTED: all write enables 0, IMem_req=0, ID_EX_Bubble=1, Halted=1. Only Reset exits.
- Counters saturate at 2^CNT_W−1 and never wrap.
- Simultaneous events: a branch and a load_use in the same cycle resolve as the branch, with no stall counted. ID_Halt with EX_BranchTaken resolves as the branch (the halt is squashed).

Decomposition:
- Shared constants file (alongside WORD_SIZE): state encodings RUN/FETCH_WAIT/HALTED and the REG_ADDR_W default.
- One natural sub-module: sat_counter (CNT_W, inc, clear), instantiated twice.
- Hazard comparison stays inline.

Test Plan:
- Reset held 3 cycles, then released with IMem_ready=1 → first cycle: PC_Write=1, IF_ID_Write=1, ID_EX_Bubble=1; second cycle: ID_EX_Bubble=0; counters 0.
- EX_MemRead=1, EX_rd=2, ID_rs=2, ID_use_rs=1 for one cycle → PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1 for exactly 1 cycle; Stall_Cnt=1.
- EX_BranchTaken=1 in the same cycle as the load-use condition → IF_ID_Flush=1, ID_EX_Bubble=1, PC_Write=1; Flush_Cnt=1, Stall_Cnt unchanged.
- IMem_ready low for 5 cycles → FETCH_WAIT, Stall_Cnt=5; on ready, IF_ID_Write=1, →RUN. Low for 64 cycles → Fetch_Timeout=1, which stays 1 after ready until Reset.
- ID_Halt=1 with ID_Valid → Halted=1, all enables 0 for 10 cycles; Reset=1 → RUN, Halted=0.
- Force Stall_Cnt near saturation (CNT_W=4, 20 DMem_busy cycles) → Stall_Cnt=15, no wrap.
